// File: rtl/inst_path_pkg.sv
// -----------------------------------------------------------------------------
// inst_path_pkg
//   Shared types and constants for the instance-path decoder.
//   - state_t            : top-level FSM states
//   - DEFAULT_RADIX_LIST : packed 3-bit radices, leaf-first 2,3,4,4
//   - REM_W              : width of the serial divider remainder
//   - radix_of()         : extracts the radix of level k from a packed list
// -----------------------------------------------------------------------------
package inst_path_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int            REM_W              = 4;
   localparam int            RADIX_LIST_MAX     = 64;   // room for up to 21 levels
   localparam logic [11:0]   DEFAULT_RADIX_LIST = {3'd4, 3'd4, 3'd3, 3'd2};

   // Radix of level k; bits [3k+2:3k] of the packed list.
   function automatic logic [2:0] radix_of(input logic [RADIX_LIST_MAX-1:0] list,
                                           input int k);
      return list[3*k +: 3];
   endfunction

endpackage

// File: rtl/path_div_serial.sv
// -----------------------------------------------------------------------------
// path_div_serial
//   One-radix, MSB-first serial restoring divider. A start pulse loads the
//   dividend and clears the remainder; the next WIDTH cycles each consume one
//   dividend bit. The dividend register doubles as the quotient register:
//   dividend bits shift out at the top while quotient bits shift in at the
//   bottom, so after WIDTH cycles it holds the full quotient.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start        : load dividend and begin a divide (ignored mid-divide by top)
//   dividend     : value to divide, sampled on start
//   radix        : divisor (2..7), must be stable while busy
//   quotient     : quotient register (valid once done has been seen)
//   remainder    : remainder register (valid once done has been seen)
//   done         : high during the cycle that consumes dividend bit 0
// -----------------------------------------------------------------------------
module path_div_serial
   import inst_path_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [2:0]       radix,
   output logic [WIDTH-1:0] quotient,
   output logic [REM_W-1:0] remainder,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] rem_sub;
   logic             q_bit;

   // Previous remainder is always < radix <= 7, so its low 3 bits hold it
   // exactly and the shifted value fits in REM_W bits.
   always_comb begin
      rem_sh  = {remainder[REM_W-2:0], quotient[WIDTH-1]};
      q_bit   = (rem_sh >= REM_W'(radix));
      rem_sub = rem_sh - REM_W'(radix);
      done    = busy && (cnt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient  <= '0;
         remainder <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
      end else if (start) begin
         quotient  <= dividend;
         remainder <= '0;
         cnt       <= CNT_W'(WIDTH - 1);
         busy      <= 1'b1;
      end else if (busy) begin
         quotient  <= {quotient[WIDTH-2:0], q_bit};
         remainder <= q_bit ? rem_sub : rem_sh;
         if (cnt == '0) busy <= 1'b0;
         else           cnt  <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/inst_path_decoder.sv
// -----------------------------------------------------------------------------
// inst_path_decoder
//   Recovers the per-level branch bits and root value from a leaf identity
//   built as id = radix*parent + b. Each level divides the running value by
//   that level's radix using one shared serial divider; the remainder gives
//   the branch bit and an error flag when it is not a legal 0/1 digit.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   in_valid      : request with in_value
//   in_ready      : high only in IDLE
//   in_value      : leaf identity value
//   out_valid     : result available (DONE)
//   out_ready     : consumer accepts the result
//   out_path      : bit k = remainder[0] at level k
//   out_root      : quotient after the last level
//   out_err_mask  : bit k set when the level-k remainder exceeds 1
// Latency: out_valid rises LEVELS*(WIDTH+1) cycles after the accept edge.
// -----------------------------------------------------------------------------
module inst_path_decoder
   import inst_path_pkg::*;
#(
   parameter int                  WIDTH      = 32,
   parameter int                  LEVELS     = 4,
   parameter logic [3*LEVELS-1:0] RADIX_LIST = DEFAULT_RADIX_LIST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LEVELS-1:0] out_path,
   output logic [WIDTH-1:0]  out_root,
   output logic [LEVELS-1:0] out_err_mask
);

   localparam int                        LVL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam logic [RADIX_LIST_MAX-1:0] RADIX_EXT = RADIX_LIST_MAX'(RADIX_LIST);

   // Elaboration-time parameter checks.
   if (3*LEVELS > RADIX_LIST_MAX) begin : g_levels_chk
      $error("inst_path_decoder: LEVELS too large");
   end
   for (genvar g = 0; g < LEVELS; g++) begin : g_radix_chk
      if (RADIX_LIST[3*g +: 3] < 3'd2) begin : g_bad
         $error("inst_path_decoder: radix of a level is outside 2..7");
      end
   end

   state_t             state, state_nxt;
   logic [LVL_W-1:0]   level;
   logic [LEVELS-1:0]  path_r, err_r;
   logic [LEVELS-1:0]  path_nxt, err_nxt;
   logic               last_level;

   logic               div_start;
   logic [WIDTH-1:0]   div_dividend;
   logic [2:0]         div_radix;
   logic [WIDTH-1:0]   div_quotient;
   logic [REM_W-1:0]   div_rem;
   logic               div_done;

   // A single divider is reused by every level; level is stable for the
   // whole DIV phase so the radix mux needs no extra register.
   assign div_radix    = radix_of(RADIX_EXT, int'(level));
   assign div_dividend = (state == IDLE) ? in_value : div_quotient;
   assign last_level   = (level == LVL_W'(LEVELS - 1));
   assign in_ready     = (state == IDLE);

   path_div_serial #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (div_dividend),
      .radix     (div_radix),
      .quotient  (div_quotient),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Working path/err with the current level's digit merged in.
   always_comb begin
      path_nxt = path_r;
      err_nxt  = err_r;
      for (int k = 0; k < LEVELS; k++) begin
         if (int'(level) == k) begin
            path_nxt[k] = div_rem[0];
            err_nxt[k]  = (div_rem > REM_W'(1));
         end
      end
   end

   always_comb begin
      state_nxt = state;
      div_start = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = DIV;
               div_start = 1'b1;
            end
         end
         DIV: begin
            if (div_done) state_nxt = CHECK;
         end
         CHECK: begin
            if (last_level) begin
               state_nxt = DONE;
            end else begin
               state_nxt = DIV;
               div_start = 1'b1;   // next level divides the fresh quotient
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         level        <= '0;
         path_r       <= '0;
         err_r        <= '0;
         out_path     <= '0;
         out_root     <= '0;
         out_err_mask <= '0;
         out_valid    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  level  <= '0;
                  path_r <= '0;
                  err_r  <= '0;
               end
            end
            CHECK: begin
               path_r <= path_nxt;
               err_r  <= err_nxt;
               if (last_level) begin
                  // Result registers change only here, so they hold
                  // between operations and never show a partial decode.
                  level        <= '0;
                  out_path     <= path_nxt;
                  out_err_mask <= err_nxt;
                  out_root     <= div_quotient;
                  out_valid    <= 1'b1;
               end else begin
                  level <= level + LVL_W'(1);
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_path_decoder.sv
// -----------------------------------------------------------------------------
// tb_inst_path_decoder
//   Directed table of leaf ids with hand-computed path/root/error results
//   (radices leaf-first 2,3,4,4), plus backpressure and mid-decode reset
//   sequences.
// -----------------------------------------------------------------------------
module tb_inst_path_decoder;

   localparam int WIDTH   = 32;
   localparam int LEVELS  = 4;
   localparam int LATENCY = LEVELS * (WIDTH + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_value;
   logic              out_valid;
   logic              out_ready;
   logic [LEVELS-1:0] out_path;
   logic [WIDTH-1:0]  out_root;
   logic [LEVELS-1:0] out_err_mask;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   inst_path_decoder #(.WIDTH(WIDTH), .LEVELS(LEVELS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_value     (in_value),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_path     (out_path),
      .out_root     (out_root),
      .out_err_mask (out_err_mask)
   );

   typedef struct {
      logic [WIDTH-1:0]  value;
      logic [LEVELS-1:0] path;
      logic [WIDTH-1:0]  root;
      logic [LEVELS-1:0] err;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request and wait (bounded) for out_valid; returns cycles
   // counted from the accept edge. out_ready is left to the caller.
   task automatic issue(input logic [WIDTH-1:0] v, output int cyc);
      @(negedge clk);
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_value = v;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 1000) begin
         if (in_ready) begin
            check("in_ready_while_busy", 32'(in_ready), 32'd0);
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_ready", 32'(out_valid), 32'd0);
      check("in_ready_after_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int cyc;
      issue(v.value, cyc);
      check("latency", 32'(cyc), 32'(LATENCY));
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_path", 32'(out_path), 32'(v.path));
      check("out_root", out_root, v.root);
      check("out_err_mask", 32'(out_err_mask), 32'(v.err));
      release_result();
   endtask

   initial begin
      int cyc;
      int stable;

      //         value          path     root         err
      vecs[0] = '{32'd33,         4'b1111, 32'd0,        4'b0000};
      vecs[1] = '{32'd672,        4'b0000, 32'd7,        4'b0000};
      vecs[2] = '{32'd5,          4'b0001, 32'd0,        4'b0010};
      vecs[3] = '{32'hFFFF_FFFF,  4'b0011, 32'd44739242, 4'b1100};
      vecs[4] = '{32'd0,          4'b0000, 32'd0,        4'b0000};
      vecs[5] = '{32'd1,          4'b0001, 32'd0,        4'b0000};
      vecs[6] = '{32'd96,         4'b0000, 32'd1,        4'b0000};
      vecs[7] = '{32'd7,          4'b0101, 32'd0,        4'b0000};
      vecs[8] = '{32'd23,         4'b0101, 32'd0,        4'b0110};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_value  = '0;
      out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_path", 32'(out_path), 32'd0);
      check("rst_out_root", out_root, 32'd0);
      check("rst_out_err", 32'(out_err_mask), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Backpressure: hold the result 20 cycles, ignore a stray request.
      issue(32'd672, cyc);
      check("bp_latency", 32'(cyc), 32'(LATENCY));
      stable = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            in_valid = 1'b1;
            in_value = 32'd33;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (out_valid && !in_ready && out_path == 4'b0000 &&
             out_root == 32'd7 && out_err_mask == 4'b0000) stable++;
      end
      in_valid = 1'b0;
      check("bp_stable_cycles", 32'(stable), 32'd20);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_idle_next_cycle", 32'(in_ready), 32'd1);
      check("bp_valid_fell", 32'(out_valid), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("bp_no_stray_start", 32'(in_ready), 32'd1);
      check("bp_root_held", out_root, 32'd7);

      // Reset 50 cycles into a decode.
      @(negedge clk);
      in_valid = 1'b1;
      in_value = 32'd33;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (49) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_root", out_root, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/inst_path_decoder.md
Name: inst_path_decoder

Overview:
- Inverse of the hierarchical instance-identity encoding used in the parameterised-hierarchy tests. In that encoding, each level passes `radix*i + b` to its child, with branch bit b in {0,1}.
- This block takes a leaf identity value and recovers, by iterative mixed-radix division, the branch bit at each level plus the root value.
- It flags any level whose remainder is not a legal branch bit.
- It sits beside bench monitors and checkers that must map a displayed leaf id back to an instance path.

Parameters:
- WIDTH, 32: width of the identity value and root.
- LEVELS, 4: number of radix levels decoded. Index 0 is the leaf-most level.
- RADIX_LIST, {3'd4,3'd4,3'd3,3'd2}: packed 3-bit radices. Bits [3k+2:3k] give the radix of level k; the default is leaf-first 2,3,4,4. Each radix must be in 2..7; any other value is an elaboration error.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input request.
- in_ready, output, 1: block can accept a request. High only in IDLE.
- in_value, input, WIDTH: leaf identity value.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_path, output, LEVELS: bit k is the branch at level k, equal to remainder[0].
- out_root, output, WIDTH: final quotient after all levels.
- out_err_mask, output, LEVELS: bit k is set if the level-k remainder is greater than 1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces state to IDLE immediately.
  - It clears the accumulator, level counter, out_path, out_root, out_err_mask and out_valid to 0.
  - in_ready is decoded from state, so it is 1 while in reset and in IDLE.
- States: IDLE, DIV, CHECK, DONE.
- IDLE:
  - On in_valid and in_ready at a clock edge: acc = in_value, level = 0, path = 0, err = 0, bit counter = WIDTH-1, go to DIV.
- DIV (WIDTH cycles):
  - Serial restoring divide of acc by RADIX[level], MSB first.
  - Each cycle: rem = {rem[2:0], acc_bit}. If rem >= radix, then rem -= radix and the quotient bit is 1; otherwise the quotient bit is 0.
  - rem is 4 bits wide and cleared at the start of each level.
  - After the bit-0 cycle, go to CHECK.
- CHECK (1 cycle):
  - path[level] = rem[0].
  - err[level] = (rem > 1).
  - acc = quotient; level++.
  - If level was LEVELS-1, go to DONE; otherwise go to DIV.
- DONE:
  - out_valid = 1. out_path, out_root and out_err_mask are stable while out_valid is high.
  - On out_ready, the next state is IDLE and out_valid falls.
  - Outputs hold their last values until the next DONE.
- Latency: out_valid rises exactly LEVELS*(WIDTH+1) cycles after the accept edge (132 with defaults). Throughput is one request per latency+2 cycles, minimum.
- Illegal digit: decoding continues with the true quotient. The error is sticky per level, and out_path still reports rem[0].
- in_valid outside IDLE is ignored. The request is not latched and in_ready stays 0.
- out_ready outside DONE has no effect.
- Value 0 decodes to path 0, root 0, no error.
- Reset mid-DIV or mid-DONE aborts the operation. No partial result is ever presented.

Decomposition:
- Package inst_path_pkg holds:
  - the state enum;
  - the default radix constant;
  - the REM_W=4 constant;
  - a function radix_of(list, k).
- Sub-module path_div_serial: a one-radix, MSB-first serial restoring divider.
  - Inputs: start, dividend, radix.
  - Outputs: quotient, remainder, done.
  - The top FSM reuses this single instance across levels.

Test Plan:
- Legal all-ones path: in_value=33 -> after 132 cycles, out_path=4'b1111, out_root=0, out_err_mask=0.
- Legal all-zeros path: in_value=672 -> out_path=4'b0000, out_root=7, out_err_mask=0.
- Illegal digit at level 1: in_value=5 -> out_path=4'b0001, out_err_mask=4'b0010, out_root=0.
- Maximum input: in_value=32'hFFFFFFFF -> out_path=4'b0011, out_err_mask=4'b1100, out_root=44739242.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in DONE: out_valid and outputs stay stable, and in_ready=0.
  - A second in_valid pulse during this time is ignored.
  - Raise out_ready: IDLE is entered the next cycle.
- Reset mid-operation: pull rst_n low at cycle 50 of a decode -> out_valid=0 and in_ready=1 immediately. After release, a fresh decode of 33 gives the correct result.
